cmd_cfg_gen: RTL and testbench

Parametrised command/configuration engine for the logic-analyzer core. It decodes 16-bit host commands arriving from the UART command receiver and maintains the capture configuration register file for NUM_CH channels. It answers register reads and writes with a single response byte, and streams a full channel dump out of the capture RAM with circular wrap-around. It sits between the UART wrapper (cmd/cmd_rdy, resp/send_resp/resp_sent) and the trigger, capture and RAM logic.

---
 rtl/cmd_cfg_gen.sv | 277 +++++++++++++++++++++++++++
 tb/tb_cmd_cfg_gen.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_cfg_gen.sv
// cmd_cfg_gen: host command decoder and capture configuration register file.
//
// Decodes 16-bit host commands (read / write / dump), answers each read or
// write with a single response byte, and streams a whole channel out of the
// capture RAM starting at the oldest sample, wrapping at the end of the RAM.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd, cmd_rdy       host command and its valid flag (held until clr_cmd_rdy)
//   resp_sent          UART finished transmitting resp
//   set_capture_done   capture logic pulse, sets TrigCfg[5]
//   cap_ptr            oldest-sample RAM address, start of a dump
//   rdata, raddr       capture RAM read port (1-cycle latency), dump address
//   dumping            high while a channel dump is in progress
//   resp, send_resp    response byte and its one-cycle transmit strobe
//   clr_cmd_rdy        one-cycle pulse: command fully handled
//   TrigCfg .. trig_pos  configuration register outputs
module cmd_cfg_gen #(
    parameter int unsigned NUM_CH       = 5,
    parameter int unsigned ENTRIES      = 384,
    parameter int unsigned LOG2_ENTRIES = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [15:0]               cmd,
    input  logic                      cmd_rdy,
    input  logic                      resp_sent,
    input  logic                      set_capture_done,
    input  logic [LOG2_ENTRIES-1:0]   cap_ptr,
    input  logic [8*NUM_CH-1:0]       rdata,
    output logic [LOG2_ENTRIES-1:0]   raddr,
    output logic                      dumping,
    output logic [7:0]                resp,
    output logic                      send_resp,
    output logic                      clr_cmd_rdy,
    output logic [5:0]                TrigCfg,
    output logic [5*NUM_CH-1:0]       ChTrigCfg,
    output logic [3:0]                decimator,
    output logic [7:0]                VIH,
    output logic [7:0]                VIL,
    output logic [7:0]                matchH,
    output logic [7:0]                matchL,
    output logic [7:0]                maskH,
    output logic [7:0]                maskL,
    output logic [7:0]                baud_cntH,
    output logic [7:0]                baud_cntL,
    output logic [LOG2_ENTRIES-1:0]   trig_pos
);

    localparam int unsigned TpHiW = LOG2_ENTRIES - 8;
    localparam logic [LOG2_ENTRIES-1:0] LastIdx = LOG2_ENTRIES'(ENTRIES - 1);

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpDump  = 2'b10;

    localparam logic [7:0] Ack = 8'hA5;
    localparam logic [7:0] Nak = 8'hEE;

    typedef enum logic [2:0] {StIdle, StExec, StSend, StWait, StDrd, StDlat} state_e;

    state_e state_q, state_d;

    logic [15:0]             cmd_q, cmd_d;
    logic [7:0]              resp_q, resp_d;
    logic [LOG2_ENTRIES-1:0] raddr_q, raddr_d;
    logic [LOG2_ENTRIES-1:0] cnt_q, cnt_d;
    logic                    dumping_q, dumping_d;
    logic                    clr_q, clr_d;
    logic                    reg_we;

    // Register file.
    logic [5:0]              trig_cfg_q;
    logic [3:0]              decim_q;
    logic [7:0]              vih_q, vil_q, match_h_q, match_l_q, mask_h_q, mask_l_q;
    logic [7:0]              baud_h_q, baud_l_q;
    logic [LOG2_ENTRIES-1:0] trig_pos_q;
    // Sized to the full 3-bit channel index; entries at NUM_CH and above are never written.
    logic [4:0]              ch_trig_q [8];

    // Fields of the latched command.
    logic [1:0] opcode;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [2:0] dump_ch;

    assign opcode  = cmd_q[15:14];
    assign addr    = cmd_q[13:8];
    assign wdata   = cmd_q[7:0];
    assign dump_ch = cmd_q[10:8];

    logic       mapped;
    logic [7:0] rd_val;
    logic       dump_ok;
    logic [7:0] dump_byte;

    // Address decode and read mux.
    always_comb begin
        mapped = 1'b1;
        rd_val = 8'h00;
        case (addr)
            6'h00: rd_val = {2'b00, trig_cfg_q};
            6'h01: rd_val = {4'h0, decim_q};
            6'h02: rd_val = vih_q;
            6'h03: rd_val = vil_q;
            6'h04: rd_val = match_h_q;
            6'h05: rd_val = match_l_q;
            6'h06: rd_val = mask_h_q;
            6'h07: rd_val = mask_l_q;
            6'h08: rd_val = baud_h_q;
            6'h09: rd_val = baud_l_q;
            6'h0A: rd_val = 8'(trig_pos_q[LOG2_ENTRIES-1:8]);
            6'h0B: rd_val = trig_pos_q[7:0];
            default: begin
                if (addr[5:3] == 3'b010 && addr[2:0] < 3'(NUM_CH)) begin
                    rd_val = {3'b000, ch_trig_q[addr[2:0]]};
                end else begin
                    mapped = 1'b0;
                end
            end
        endcase
    end

    assign dump_ok = (dump_ch != 3'd0) && (dump_ch <= 3'(NUM_CH));

    // Channel n occupies rdata[8n-1:8(n-1)].
    always_comb begin
        dump_byte = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (dump_ch == 3'(i + 1)) dump_byte = rdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cmd_q     <= 16'h0000;
            resp_q    <= 8'h00;
            raddr_q   <= '0;
            cnt_q     <= '0;
            dumping_q <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            resp_q    <= resp_d;
            raddr_q   <= raddr_d;
            cnt_q     <= cnt_d;
            dumping_q <= dumping_d;
            clr_q     <= clr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        resp_d    = resp_q;
        raddr_d   = raddr_q;
        cnt_d     = cnt_q;
        dumping_d = dumping_q;
        clr_d     = 1'b0;
        reg_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // cmd_rdy is still high in the cycle clr_cmd_rdy is asserted; do not re-take it.
                if (cmd_rdy && !clr_q) begin
                    cmd_d   = cmd;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StSend;
                case (opcode)
                    OpRead: resp_d = mapped ? rd_val : Nak;
                    OpWrite: begin
                        if (mapped) begin
                            reg_we = 1'b1;
                            resp_d = Ack;
                        end else begin
                            resp_d = Nak;
                        end
                    end
                    OpDump: begin
                        if (dump_ok) begin
                            raddr_d   = cap_ptr;
                            dumping_d = 1'b1;
                            cnt_d     = '0;
                            state_d   = StDrd;
                        end else begin
                            resp_d = Nak;
                        end
                    end
                    default: resp_d = Nak;
                endcase
            end
            StSend: state_d = StWait;
            StWait: begin
                if (resp_sent) begin
                    if (dumping_q && cnt_q < LastIdx) begin
                        cnt_d   = cnt_q + 1'b1;
                        raddr_d = (raddr_q == LastIdx) ? '0 : raddr_q + 1'b1;
                        state_d = StDrd;
                    end else begin
                        clr_d     = 1'b1;
                        dumping_d = 1'b0;
                        state_d   = StIdle;
                    end
                end
            end
            StDrd: state_d = StDlat;
            StDlat: begin
                resp_d  = dump_byte;
                state_d = StSend;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_cfg_q <= 6'h03;
            decim_q    <= 4'h0;
            vih_q      <= 8'hAA;
            vil_q      <= 8'h55;
            match_h_q  <= 8'h00;
            match_l_q  <= 8'h00;
            mask_h_q   <= 8'h00;
            mask_l_q   <= 8'h00;
            baud_h_q   <= 8'h06;
            baud_l_q   <= 8'hC8;
            trig_pos_q <= LOG2_ENTRIES'(1);
            for (int i = 0; i < 8; i++) ch_trig_q[i] <= 5'h01;
        end else begin
            if (reg_we) begin
                case (addr)
                    6'h00: trig_cfg_q <= wdata[5:0];
                    6'h01: decim_q    <= wdata[3:0];
                    6'h02: vih_q      <= wdata;
                    6'h03: vil_q      <= wdata;
                    6'h04: match_h_q  <= wdata;
                    6'h05: match_l_q  <= wdata;
                    6'h06: mask_h_q   <= wdata;
                    6'h07: mask_l_q   <= wdata;
                    6'h08: baud_h_q   <= wdata;
                    6'h09: baud_l_q   <= wdata;
                    6'h0A: trig_pos_q[LOG2_ENTRIES-1:8] <= wdata[TpHiW-1:0];
                    6'h0B: trig_pos_q[7:0] <= wdata;
                    default: ch_trig_q[addr[2:0]] <= wdata[4:0];
                endcase
            end
            // Placed after the write so a coincident write of TrigCfg still ends with bit 5 set.
            if (set_capture_done) trig_cfg_q[5] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch_out
        assign ChTrigCfg[5*i +: 5] = ch_trig_q[i];
    end

    assign raddr       = raddr_q;
    assign dumping     = dumping_q;
    assign resp        = resp_q;
    assign send_resp   = (state_q == StSend);
    assign clr_cmd_rdy = clr_q;
    assign TrigCfg     = trig_cfg_q;
    assign decimator   = decim_q;
    assign VIH         = vih_q;
    assign VIL         = vil_q;
    assign matchH      = match_h_q;
    assign matchL      = match_l_q;
    assign maskH       = mask_h_q;
    assign maskL       = mask_l_q;
    assign baud_cntH   = baud_h_q;
    assign baud_cntL   = baud_l_q;
    assign trig_pos    = trig_pos_q;

endmodule

// File: tb/tb_cmd_cfg_gen.sv
// tb_cmd_cfg_gen: self-checking bench for cmd_cfg_gen against a register-map
// model, with a behavioural capture RAM and UART handshake driver.
module tb_cmd_cfg_gen;

    localparam int NUM_CH  = 5;
    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;
    localparam int OW      = 6 + 5*NUM_CH + 4 + 64 + LOG2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [15:0]           cmd;
    logic                  cmd_rdy, resp_sent, set_capture_done;
    logic [LOG2-1:0]       cap_ptr;
    logic [8*NUM_CH-1:0]   rdata;
    logic [LOG2-1:0]       raddr;
    logic                  dumping, send_resp, clr_cmd_rdy;
    logic [7:0]            resp;
    logic [5:0]            TrigCfg;
    logic [5*NUM_CH-1:0]   ChTrigCfg;
    logic [3:0]            decimator;
    logic [7:0]            VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL;
    logic [LOG2-1:0]       trig_pos;

    cmd_cfg_gen #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .LOG2_ENTRIES(LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp_sent(resp_sent),
        .set_capture_done(set_capture_done), .cap_ptr(cap_ptr), .rdata(rdata),
        .raddr(raddr), .dumping(dumping), .resp(resp), .send_resp(send_resp),
        .clr_cmd_rdy(clr_cmd_rdy), .TrigCfg(TrigCfg), .ChTrigCfg(ChTrigCfg),
        .decimator(decimator), .VIH(VIH), .VIL(VIL), .matchH(matchH), .matchL(matchL),
        .maskH(maskH), .maskL(maskL), .baud_cntH(baud_cntH), .baud_cntL(baud_cntL),
        .trig_pos(trig_pos)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: one byte per register address, kept already truncated to the register width.
    logic [7:0] m [64];
    logic [7:0] ram [NUM_CH][ENTRIES];
    int n_send = 0;
    int n_clr = 0;

    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) rdata[8*c +: 8] <= ram[c][raddr];
        if (send_resp) n_send <= n_send + 1;
        if (clr_cmd_rdy) n_clr <= n_clr + 1;
    end

    logic [OW-1:0] dut_outs;
    assign dut_outs = {TrigCfg, ChTrigCfg, decimator, VIH, VIL, matchH, matchL, maskH, maskL,
                       baud_cntH, baud_cntL, trig_pos};

    function automatic bit is_mapped(input int a);
        return (a <= 'h0B) || (a >= 'h10 && a < 'h10 + NUM_CH);
    endfunction

    function automatic logic [7:0] width_mask(input int a);
        if (a == 'h00) return 8'h3F;
        if (a == 'h01) return 8'h0F;
        if (a == 'h0A) return 8'((1 << (LOG2 - 8)) - 1);
        if (a >= 'h10) return 8'h1F;
        return 8'hFF;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m[i] = 8'h00;
        m['h00] = 8'h03; m['h02] = 8'hAA; m['h03] = 8'h55;
        m['h08] = 8'h06; m['h09] = 8'hC8; m['h0A] = 8'h00; m['h0B] = 8'h01;
        for (int n = 0; n < NUM_CH; n++) m['h10 + n] = 8'h01;
    endfunction

    function automatic logic [OW-1:0] model_outs();
        logic [5*NUM_CH-1:0] chv;
        logic [LOG2-1:0] tp;
        for (int n = 0; n < NUM_CH; n++) chv[5*n +: 5] = m['h10 + n][4:0];
        tp = LOG2'(m['h0A]) * 256 + LOG2'(m['h0B]);
        return {m[0][5:0], chv, m[1][3:0], m[2], m[3], m[4], m[5], m[6], m[7], m[8], m[9], tp};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; cmd_rdy = 1'b0; resp_sent = 1'b0; set_capture_done = 1'b0;
        cmd = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // One read/write transaction with the UART side emulated; delay = extra WAIT cycles.
    task automatic transact(input logic [15:0] c, input int delay, output logic [7:0] r,
                            output int nsend, output bit to);
        int s0;
        bit got;
        to = 1'b0;
        r = 8'hxx;
        @(negedge clk);
        cmd = c; cmd_rdy = 1'b1;
        s0 = n_send;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (send_resp) begin got = 1'b1; r = resp; break; end
        end
        if (!got) to = 1'b1;
        repeat (delay + 1) @(negedge clk);
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (clr_cmd_rdy) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) to = 1'b1;
        cmd_rdy = 1'b0;
        @(negedge clk);
        nsend = n_send - s0;
    endtask

    function automatic logic [7:0] model_resp(input logic [15:0] c);
        int a;
        a = int'(c[13:8]);
        case (c[15:14])
            2'b00: return is_mapped(a) ? m[a] : 8'hEE;
            2'b01: begin
                if (!is_mapped(a)) return 8'hEE;
                m[a] = c[7:0] & width_mask(a);
                return 8'hA5;
            end
            default: return 8'hEE;
        endcase
    endfunction

    task automatic test_reset();
        apply_reset();
        checks++;
        if (dut_outs !== model_outs()) begin
            failures++; $display("FAIL reset_regs got=%h want=%h", dut_outs, model_outs());
        end
        checks++;
        if ({resp, raddr, dumping, send_resp, clr_cmd_rdy} !== '0) begin
            failures++;
            $display("FAIL reset_ctl got resp=%h raddr=%h dump=%b send=%b clr=%b want all 0",
                     resp, raddr, dumping, send_resp, clr_cmd_rdy);
        end
    endtask

    task automatic test_read_defaults();
        logic [7:0] r; int ns; bit to;
        transact(16'h0800, 2, r, ns, to);
        checks++;
        if (r !== 8'h06 || ns != 1 || to) begin
            failures++; $display("FAIL read_baudH got=%h sends=%0d to=%b want=06 sends=1", r, ns, to);
        end
        transact(16'h0300, 0, r, ns, to);
        checks++;
        if (r !== 8'h55 || ns != 1 || to) begin
            failures++; $display("FAIL read_VIL got=%h sends=%0d to=%b want=55 sends=1", r, ns, to);
        end
    endtask

    task automatic test_write_latency();
        logic [7:0] r, old; int ns; bit to; bit got;
        old = m[2];
        @(negedge clk);
        cmd = 16'h4255; cmd_rdy = 1'b1;
        @(negedge clk);
        // Latched at edge k; a changed cmd must now be ignored.
        cmd = 16'h4233;
        checks++;
        if (VIH !== old || send_resp !== 1'b0) begin
            failures++; $display("FAIL write_early got VIH=%h send=%b want VIH=%h send=0", VIH, send_resp, old);
        end
        @(negedge clk);
        checks++;
        if (VIH !== 8'h55 || resp !== 8'hA5 || send_resp !== 1'b1) begin
            failures++;
            $display("FAIL write_k1 got VIH=%h resp=%h send=%b want 55 a5 1", VIH, resp, send_resp);
        end
        @(negedge clk);
        checks++;
        if (send_resp !== 1'b0) begin
            failures++; $display("FAIL send_one_cycle got send=%b want 0", send_resp);
        end
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (clr_cmd_rdy) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got) begin failures++; $display("FAIL write_clr got none want one clr_cmd_rdy"); end
        cmd_rdy = 1'b0;
        m[2] = 8'h55;
        @(negedge clk);
        transact(16'h0200, 1, r, ns, to);
        checks++;
        if (r !== 8'h55 || to) begin failures++; $display("FAIL readback_VIH got=%h want=55", r); end
        transact(16'h4AFF, 1, r, ns, to);
        transact(16'h4B80, 1, r, ns, to);
        m['h0A] = 8'h01; m['h0B] = 8'h80;
        checks++;
        if (trig_pos !== 9'h180 || dut_outs !== model_outs()) begin
            failures++; $display("FAIL trig_pos got=%h want=180", trig_pos);
        end
    endtask

    task automatic test_random_access();
        logic [7:0] r, exp; int ns; bit to;
        logic [15:0] c;
        logic [1:0] op;
        logic [5:0] a;
        for (int it = 0; it < 60; it++) begin
            op = ($urandom_range(0, 2) == 2) ? 2'b11 : 2'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) a = 6'($urandom_range(0, 11));
            else a = 6'($urandom_range(0, 63));
            c = {op, a, 8'($urandom)};
            exp = model_resp(c);
            transact(c, $urandom_range(0, 3), r, ns, to);
            checks++;
            if (r !== exp || ns != 1 || to) begin
                failures++;
                $display("FAIL rand_resp cmd=%h got=%h sends=%0d to=%b want=%h sends=1", c, r, ns, to, exp);
            end
            checks++;
            if (dut_outs !== model_outs()) begin
                failures++; $display("FAIL rand_regs cmd=%h got=%h want=%h", c, dut_outs, model_outs());
            end
        end
    endtask

    task automatic test_nak();
        logic [15:0] cl [7];
        logic [7:0] r; int ns; bit to;
        cl = '{16'h7F12, 16'hC000, 16'h8000, 16'h8600, 16'h8700, 16'h0C00, 16'h5513};
        for (int i = 0; i < 7; i++) begin
            transact(cl[i], 0, r, ns, to);
            checks++;
            if (r !== 8'hEE || ns != 1 || to || dut_outs !== model_outs() || dumping !== 1'b0) begin
                failures++;
                $display("FAIL nak cmd=%h got=%h sends=%0d to=%b regs_ok=%b want=ee sends=1", cl[i],
                         r, ns, to, dut_outs === model_outs());
            end
        end
    endtask

    task automatic test_capture_done();
        int s0; bit got;
        @(negedge clk);
        set_capture_done = 1'b1;
        @(negedge clk);
        set_capture_done = 1'b0;
        m[0] = m[0] | 8'h20;
        checks++;
        if (dut_outs !== model_outs()) begin
            failures++; $display("FAIL capdone_idle got TrigCfg=%h want=%h", TrigCfg, m[0][5:0]);
        end
        cmd = 16'h4001; cmd_rdy = 1'b1;
        s0 = n_send;
        @(negedge clk);
        set_capture_done = 1'b1;
        @(negedge clk);
        set_capture_done = 1'b0;
        m[0] = 8'h21;
        checks++;
        if (TrigCfg !== 6'h21 || resp !== 8'hA5 || send_resp !== 1'b1) begin
            failures++;
            $display("FAIL capdone_write got TrigCfg=%h resp=%h send=%b want 21 a5 1", TrigCfg, resp, send_resp);
        end
        repeat (50) @(negedge clk);
        checks++;
        if (n_send - s0 != 1 || clr_cmd_rdy !== 1'b0) begin
            failures++; $display("FAIL wait_hold got sends=%0d clr=%b want sends=1 clr=0", n_send - s0, clr_cmd_rdy);
        end
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (clr_cmd_rdy) begin got = 1'b1; break; end
            @(negedge clk);
        end
        cmd_rdy = 1'b0;
        checks++;
        if (!got || dut_outs !== model_outs()) begin
            failures++; $display("FAIL capdone_end got clr=%b TrigCfg=%h want clr=1 TrigCfg=21", got, TrigCfg);
        end
        @(negedge clk);
    endtask

    // Dumps a channel; nbytes < ENTRIES aborts with a reset after that many bytes.
    task automatic test_dump(input int ch, input int ptr, input bit ramp, input int nbytes);
        int s0, c0, bad, idx;
        bit got;
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < ENTRIES; a++)
                ram[c][a] = (ramp && c == ch - 1) ? 8'(a) : 8'($urandom);
        cap_ptr = LOG2'(ptr);
        @(negedge clk);
        cmd = {2'b10, 3'b000, 3'(ch), 8'h00}; cmd_rdy = 1'b1;
        s0 = n_send; c0 = n_clr; bad = 0;
        for (int i = 0; i < nbytes; i++) begin
            got = 1'b0;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (send_resp) begin got = 1'b1; break; end
            end
            checks++;
            if (!got) begin
                failures++; $display("FAIL dump_timeout ch=%0d byte=%0d got none want send_resp", ch, i);
                break;
            end
            idx = (ptr + i) % ENTRIES;
            checks++;
            if (resp !== ram[ch-1][idx] || dumping !== 1'b1) begin
                failures++; bad++;
                if (bad < 8) $display("FAIL dump_byte ch=%0d byte=%0d got=%h dumping=%b want=%h dumping=1",
                                      ch, i, resp, dumping, ram[ch-1][idx]);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
            resp_sent = 1'b1;
            @(negedge clk);
            resp_sent = 1'b0;
        end
        if (nbytes < ENTRIES) begin
            rst_n = 1'b0; cmd_rdy = 1'b0;
            #1;
            model_reset();
            checks++;
            if (dumping !== 1'b0 || dut_outs !== model_outs() || resp !== 8'h00 || raddr !== '0) begin
                failures++;
                $display("FAIL reset_mid_dump got dumping=%b resp=%h raddr=%h regs_ok=%b want 0 0 0 1",
                         dumping, resp, raddr, dut_outs === model_outs());
            end
            @(negedge clk);
            rst_n = 1'b1;
            s0 = n_send; c0 = n_clr;
            repeat (40) @(negedge clk);
            checks++;
            if (n_send != s0 || n_clr != c0 || dumping !== 1'b0) begin
                failures++; $display("FAIL post_reset_quiet got sends=%0d clrs=%0d want 0 0", n_send - s0, n_clr - c0);
            end
        end else begin
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (clr_cmd_rdy) begin got = 1'b1; break; end
                @(negedge clk);
            end
            cmd_rdy = 1'b0;
            repeat (5) @(negedge clk);
            checks++;
            if (!got || n_clr - c0 != 1 || n_send - s0 != ENTRIES || dumping !== 1'b0) begin
                failures++;
                $display("FAIL dump_end ch=%0d got clrs=%0d sends=%0d dumping=%b want clrs=1 sends=%0d dumping=0",
                         ch, n_clr - c0, n_send - s0, dumping, ENTRIES);
            end
        end
    endtask

    initial begin
        cap_ptr = '0;
        for (int c = 0; c < NUM_CH; c++)
            for (int a = 0; a < ENTRIES; a++) ram[c][a] = 8'h00;
        test_reset();
        test_read_defaults();
        test_write_latency();
        test_random_access();
        test_nak();
        test_capture_done();
        test_dump(2, 380, 1'b1, ENTRIES);
        test_dump($urandom_range(1, NUM_CH), $urandom_range(0, ENTRIES - 1), 1'b0, ENTRIES);
        test_dump(NUM_CH, ENTRIES - 1, 1'b0, ENTRIES);
        test_dump($urandom_range(1, NUM_CH), $urandom_range(0, ENTRIES - 1), 1'b0, 10);
        test_read_defaults();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
